// File: rtl/present_decrypt.sv
// ============================================================================
//  Module      : present_decrypt
//  Description : Iterative PRESENT-80 decryption core. Expands the cipher key
//                forward to the last round key, then runs the inverse rounds
//                while unwinding the key schedule in place.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module present_decrypt (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Start,
    input  logic [79:0] orig_key,
    input  logic [63:0] ciphertext,
    output logic [63:0] plaintext,
    output logic        Busy,
    output logic        Done
);

    // Algorithm-fixed sizes; kept local so they cannot be overridden.
    localparam int SIZE       = 64;
    localparam int KEY_SIZE   = 80;
    localparam int NUM_ROUNDS = 31;

    localparam logic [4:0] c_LAST_RND = 5'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        KEYEXP = 2'd1,
        WHITEN = 2'd2,
        DEC    = 2'd3
    } state_t;

    state_t                r_fsm;
    state_t                w_fsm_nxt;
    logic [KEY_SIZE-1:0]   r_key;
    logic [KEY_SIZE-1:0]   w_key_nxt;
    logic [SIZE-1:0]       r_state;
    logic [SIZE-1:0]       w_state_nxt;
    logic [4:0]            r_cnt;
    logic [4:0]            w_cnt_nxt;
    logic [SIZE-1:0]       r_pt;
    logic [SIZE-1:0]       w_pt_nxt;
    logic                  r_done;
    logic                  w_done_nxt;
    logic [SIZE-1:0]       w_perm;
    logic [SIZE-1:0]       w_round;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC;  4'h1: sbox = 4'h5;  4'h2: sbox = 4'h6;  4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9;  4'h5: sbox = 4'h0;  4'h6: sbox = 4'hA;  4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3;  4'h9: sbox = 4'hE;  4'hA: sbox = 4'hF;  4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4;  4'hD: sbox = 4'h7;  4'hE: sbox = 4'h1;  default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sinv(input logic [3:0] x);
        case (x)
            4'h0: sinv = 4'h5;  4'h1: sinv = 4'hE;  4'h2: sinv = 4'hF;  4'h3: sinv = 4'h8;
            4'h4: sinv = 4'hC;  4'h5: sinv = 4'h1;  4'h6: sinv = 4'h2;  4'h7: sinv = 4'hD;
            4'h8: sinv = 4'hB;  4'h9: sinv = 4'h4;  4'hA: sinv = 4'h6;  4'hB: sinv = 4'h3;
            4'hC: sinv = 4'h0;  4'hD: sinv = 4'h7;  4'hE: sinv = 4'h9;  default: sinv = 4'hA;
        endcase
    endfunction

    // Forward key-schedule step: rotate left 61, S-box top nibble, mix counter.
    function automatic logic [KEY_SIZE-1:0] key_fwd(input logic [KEY_SIZE-1:0] k,
                                                    input logic [4:0] rc);
        logic [KEY_SIZE-1:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ rc;
        return t;
    endfunction

    // Exact inverse of key_fwd, so the schedule can be walked backwards in place.
    function automatic logic [KEY_SIZE-1:0] key_inv(input logic [KEY_SIZE-1:0] k,
                                                    input logic [4:0] rc);
        logic [KEY_SIZE-1:0] t;
        t          = k;
        t[19:15]   = t[19:15] ^ rc;
        t[79:76]   = sinv(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    // Inverse bit permutation: bit j lands at (4*j) mod 63, bit 63 stays put.
    for (genvar j = 0; j < 63; j++) begin : g_invp
        assign w_perm[(4*j) % 63] = r_state[j];
    end
    assign w_perm[63] = r_state[63];

    // Inverse S-box layer followed by the current round key.
    for (genvar n = 0; n < 16; n++) begin : g_sinv
        assign w_round[4*n +: 4] = sinv(w_perm[4*n +: 4]) ^ r_key[16 + 4*n +: 4];
    end

    assign Busy      = (r_fsm != IDLE);
    assign plaintext = r_pt;
    assign Done      = r_done;

    // Next-state and datapath update selection.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_key_nxt   = r_key;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pt_nxt    = r_pt;
        w_done_nxt  = 1'b0;
        case (r_fsm)
            IDLE: begin
                if (Start) begin
                    w_key_nxt   = orig_key;
                    w_state_nxt = ciphertext;
                    w_cnt_nxt   = 5'd1;
                    w_fsm_nxt   = KEYEXP;
                end
            end
            KEYEXP: begin
                w_key_nxt = key_fwd(r_key, r_cnt);
                // Counter parks at the last round so it never wraps.
                if (r_cnt == c_LAST_RND) begin
                    w_fsm_nxt = WHITEN;
                end else begin
                    w_cnt_nxt = r_cnt + 5'd1;
                end
            end
            WHITEN: begin
                w_state_nxt = r_state ^ r_key[79:16];
                w_key_nxt   = key_inv(r_key, c_LAST_RND);
                w_cnt_nxt   = c_LAST_RND;
                w_fsm_nxt   = DEC;
            end
            DEC: begin
                w_state_nxt = w_round;
                if (r_cnt > 5'd1) begin
                    w_key_nxt = key_inv(r_key, r_cnt - 5'd1);
                    w_cnt_nxt = r_cnt - 5'd1;
                end else begin
                    w_pt_nxt   = w_round;
                    w_done_nxt = 1'b1;
                    w_fsm_nxt  = IDLE;
                end
            end
            default: w_fsm_nxt = IDLE;
        endcase
    end

    // State, datapath and output registers with asynchronous clear.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_fsm   <= IDLE;
            r_key   <= '0;
            r_state <= '0;
            r_cnt   <= '0;
            r_pt    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_fsm   <= w_fsm_nxt;
            r_key   <= w_key_nxt;
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pt    <= w_pt_nxt;
            r_done  <= w_done_nxt;
        end
    end

endmodule

`default_nettype wire
